// File: rtl/button_event_arbiter.sv
// button_event_arbiter: shared-tick debounce for N_BTN buttons feeding a round-robin valid/ready event port
module button_event_arbiter #(
   parameter int N_BTN        = 4,
   parameter int TICK_MAX     = 999_999,
   parameter int STABLE_TICKS = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_BTN-1:0]         btn_in,
   output logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic                     evt_edge,
   output logic [N_BTN-1:0]         ovf,
   input  logic                     ovf_clr
);
   localparam int IW = $clog2(N_BTN);
   localparam int TW = TICK_MAX > 0 ? $clog2(TICK_MAX + 1) : 1;
   logic [N_BTN-1:0]      sync1, sync2, pending, pend_edge, flip, gnt;
   logic [N_BTN-1:0][3:0] cnt;
   logic [TW-1:0]         tick_cnt;
   logic [IW-1:0]         last_grant, sel, idx;
   logic                  tick, load, found;
   assign tick  = tick_cnt == TW'(TICK_MAX);
   assign load  = !evt_valid || evt_ready;
   assign found = |pending;
   assign gnt   = (load && found) ? (N_BTN'(1) << sel) : '0;
   always_comb begin
      for (int i = 0; i < N_BTN; i++)
         flip[i] = (sync2[i] != btn_level[i]) && tick && (cnt[i] == 4'(STABLE_TICKS - 1));
   end
   // descending scan so the nearest pending channel after last_grant wins
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = N_BTN; k >= 1; k--) begin
         idx = IW'((int'(last_grant) + k) % N_BTN);
         if (pending[idx]) sel = idx;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         tick_cnt   <= '0;
         cnt        <= '0;
         btn_level  <= '0;
         pending    <= '0;
         pend_edge  <= '0;
         ovf        <= '0;
         evt_valid  <= 1'b0;
         evt_id     <= '0;
         evt_edge   <= 1'b0;
         last_grant <= IW'(N_BTN - 1);
      end else begin
         sync1     <= btn_in;
         sync2     <= sync1;
         tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
         for (int i = 0; i < N_BTN; i++)
            cnt[i] <= (sync2[i] == btn_level[i] || flip[i]) ? 4'd0 : cnt[i] + 4'(tick);
         btn_level <= btn_level ^ flip;
         // a flip on the granted channel re-arms pending instead of counting as overflow
         pending   <= (pending & ~gnt) | flip;
         pend_edge <= (pend_edge & ~flip) | (flip & ~btn_level);
         ovf       <= (ovf & ~{N_BTN{ovf_clr}}) | (flip & pending & ~gnt);
         if (load) begin
            evt_valid <= found;
            if (found) begin
               evt_id     <= sel;
               evt_edge   <= pend_edge[sel];
               last_grant <= sel;
            end
         end
      end
   end
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: vector table, directed corner cases and random run against a behavioural model
module tb_button_event_arbiter;
   localparam int N = 4, TM = 9, ST = 3;
   logic       clk = 1'b0, reset = 1'b1, evt_ready = 1'b0, ovf_clr = 1'b0;
   logic [3:0] btn_in = '0;
   logic [3:0] btn_level, ovf;
   logic       evt_valid, evt_edge;
   logic [1:0] evt_id;
   int n_cmp = 0, n_bad = 0;
   logic [2:0] acc[$];
   logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_pend = '0, m_pedge = '0, m_ovf = '0;
   logic       m_valid = 1'b0, m_edge = 1'b0;
   int         m_id = 0, m_last = N - 1, m_k = 0;
   int         m_ticks[N];

   typedef struct {
      logic rst; logic [3:0] btn; logic rdy; int cyc;
      logic [3:0] lvl; logic vld; logic [1:0] id; logic edg; logic [3:0] ov;
   } vec_t;
   vec_t tbl[6];

   button_event_arbiter #(.N_BTN(N), .TICK_MAX(TM), .STABLE_TICKS(ST)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .btn_level(btn_level),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_edge(evt_edge), .ovf(ovf), .ovf_clr(ovf_clr));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // model: sync delay of two samples, tick every TM+1 edges, flip after ST ticks of continuous difference
   task automatic model_step();
      logic [3:0] seen;
      logic tick, done;
      int c;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_pedge = '0; m_ovf = '0;
         m_valid = 1'b0; m_edge = 1'b0; m_id = 0; m_last = N - 1; m_k = 0;
         for (int i = 0; i < N; i++) m_ticks[i] = 0;
         return;
      end
      tick = (m_k % (TM + 1)) == TM;
      m_k++;
      seen = m_s2; m_s2 = m_s1; m_s1 = btn_in;
      if (!m_valid || evt_ready) begin
         m_valid = 1'b0;
         done = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!done && m_pend[c]) begin
               done = 1'b1; m_valid = 1'b1; m_id = c; m_edge = m_pedge[c];
               m_pend[c] = 1'b0; m_last = c;
            end
         end
      end
      if (ovf_clr) m_ovf = '0;
      for (int i = 0; i < N; i++) begin
         if (seen[i] == m_lvl[i]) m_ticks[i] = 0;
         else if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == ST) begin
               m_ticks[i] = 0;
               m_lvl[i] = ~m_lvl[i];
               if (m_pend[i]) m_ovf[i] = 1'b1;
               m_pend[i] = 1'b1;
               m_pedge[i] = m_lvl[i];
            end
         end
      end
   endtask

   task automatic cyc();
      if (!reset && evt_valid === 1'b1 && evt_ready) acc.push_back({evt_id, evt_edge});
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_level", 32'(btn_level), 32'(m_lvl));
      chk("cyc_valid", 32'(evt_valid), 32'(m_valid));
      chk("cyc_id", 32'(evt_id), 32'(m_id));
      chk("cyc_edge", 32'(evt_edge), 32'(m_edge));
      chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic do_reset();
      reset = 1'b1; btn_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
      repeat (2) cyc();
      reset = 1'b0;
      acc.delete();
   endtask

   task automatic chk_acc(input string nm, input logic [2:0] e0, input logic [2:0] e1,
                          input logic [2:0] e2, input logic [2:0] e3, input int n);
      logic [2:0] e[4];
      e = '{e0, e1, e2, e3};
      chk({nm, "_count"}, 32'(acc.size()), 32'(n));
      for (int i = 0; i < n && i < acc.size(); i++) chk({nm, "_evt"}, 32'(acc[i]), 32'(e[i]));
   endtask

   initial begin
      int hold[N];
      tbl[0] = '{1'b1, 4'b0000, 1'b0,  3, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[1] = '{1'b0, 4'b0010, 1'b0, 30, 4'b0010, 1'b0, 2'd0, 1'b0, 4'b0000};
      tbl[2] = '{1'b0, 4'b0010, 1'b0,  1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0000};
      tbl[3] = '{1'b0, 4'b0010, 1'b0,  5, 4'b0010, 1'b1, 2'd1, 1'b1, 4'b0000};
      tbl[4] = '{1'b0, 4'b0010, 1'b1,  1, 4'b0010, 1'b0, 2'd1, 1'b1, 4'b0000};
      tbl[5] = '{1'b0, 4'b0000, 1'b1, 40, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000};
      for (int r = 0; r < 6; r++) begin
         reset = tbl[r].rst; btn_in = tbl[r].btn; evt_ready = tbl[r].rdy; ovf_clr = 1'b0;
         repeat (tbl[r].cyc) cyc();
         chk("tbl_level", 32'(btn_level), 32'(tbl[r].lvl));
         chk("tbl_valid", 32'(evt_valid), 32'(tbl[r].vld));
         chk("tbl_id", 32'(evt_id), 32'(tbl[r].id));
         chk("tbl_edge", 32'(evt_edge), 32'(tbl[r].edg));
         chk("tbl_ovf", 32'(ovf), 32'(tbl[r].ov));
      end

      // bouncing ch2 never settles, then a clean hold gives one press
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         btn_in[2] = ((i / 7) % 2) != 0;
         cyc();
      end
      chk("bounce_level", 32'(btn_level[2]), 32'(0));
      chk("bounce_events", 32'(acc.size()), 32'(0));
      btn_in = 4'b0100;
      repeat (45) cyc();
      chk_acc("bounce_press", 3'b101, 3'b000, 3'b000, 3'b000, 1);

      // simultaneous ch0/ch3 flips, round-robin order on press and release
      do_reset();
      btn_in = 4'b1001;
      repeat (40) cyc();
      chk("rr_held_id", 32'(evt_id), 32'(0));
      chk("rr_held_valid", 32'(evt_valid), 32'(1));
      evt_ready = 1'b1;
      repeat (3) cyc();
      btn_in = 4'b0000;
      repeat (45) cyc();
      chk_acc("rr", 3'b001, 3'b111, 3'b000, 3'b110, 4);

      // overwrite of an unconsumed ch1 event while the output is stalled
      do_reset();
      for (int p = 0; p < 4; p++) begin
         btn_in = (p % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (40) cyc();
      end
      chk("ovf_held_id", 32'(evt_id), 32'(1));
      chk("ovf_held_edge", 32'(evt_edge), 32'(1));
      chk("ovf_set", 32'(ovf), 32'(4'b0010));
      evt_ready = 1'b1;
      repeat (3) cyc();
      chk_acc("ovf_drain", 3'b011, 3'b010, 3'b000, 3'b000, 2);
      chk("ovf_sticky", 32'(ovf), 32'(4'b0010));
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(ovf), 32'(0));

      // one-cycle reset with an event presented and ch2 mid-debounce
      do_reset();
      btn_in = 4'b0010;
      repeat (35) cyc();
      btn_in = 4'b0110;
      repeat (15) cyc();
      chk("rst_pre_valid", 32'(evt_valid), 32'(1));
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_level", 32'(btn_level), 32'(0));
      chk("rst_valid", 32'(evt_valid), 32'(0));
      chk("rst_id", 32'(evt_id), 32'(0));
      chk("rst_edge", 32'(evt_edge), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      acc.delete();
      evt_ready = 1'b1;
      repeat (5) cyc();
      chk("rst_no_replay", 32'(acc.size()), 32'(0));

      // ch2 release flips on the very edge its pending press is granted
      do_reset();
      btn_in = 4'b0101;
      repeat (35) cyc();
      btn_in = 4'b0001;
      repeat (24) cyc();
      chk("same_pre_level", 32'(btn_level[2]), 32'(1));
      evt_ready = 1'b1;
      cyc();
      chk("same_level", 32'(btn_level[2]), 32'(0));
      chk("same_id", 32'(evt_id), 32'(2));
      chk("same_edge", 32'(evt_edge), 32'(1));
      repeat (3) cyc();
      chk_acc("same", 3'b001, 3'b101, 3'b100, 3'b000, 3);
      chk("same_ovf", 32'(ovf), 32'(0));

      // random traffic against the model
      do_reset();
      for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 70);
      for (int i = 0; i < 4000; i++) begin
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               btn_in[c] = ~btn_in[c];
               hold[c] = $urandom_range(1, 70);
            end else hold[c]--;
         end
         evt_ready = (i % 300 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         ovf_clr = $urandom_range(0, 60) == 0;
         reset = $urandom_range(0, 1500) == 0;
         cyc();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
